// File: rtl/iterative_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface iterative_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/iterative_muldiv.sv
// RV32M execute unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// state | meaning: IDLE idle | CALC one bit per cycle | DONE result_o valid, valid_o high
module iterative_muldiv #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  iterative_muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem, div_sel, final_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Operand conditioning at accept time.
  always_comb begin
    signed_a = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
               (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    signed_b = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    sign_a   = signed_a & bus.src_a_i[XLEN-1];
    sign_b   = signed_b & bus.src_b_i[XLEN-1];
    mag_a    = sign_a ? -bus.src_a_i : bus.src_a_i;
    mag_b    = sign_b ? -bus.src_b_i : bus.src_b_i;
    div_zero = bus.op_i[2] && (bus.src_b_i == '0);
    div_ovf  = bus.op_i[2] && !bus.op_i[0] &&
               (bus.src_a_i == INT_MIN) && (bus.src_b_i == '1);
    if (div_zero)
      special_res = bus.op_i[1] ? bus.src_a_i : '1;
    else
      special_res = bus.op_i[1] ? '0 : bus.src_a_i;
  end

  // One iteration of each datapath; acc holds {hi, lo} for both.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ok    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ok ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ok};
    prod      = neg_q ? -mul_next : mul_next;
    div_sel   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    if (op_q[2])
      final_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00)
      final_res = prod[XLEN-1:0];
    else
      final_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start_i && !bus.flush_i) begin
          if (div_zero || div_ovf) begin
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            op_d    = bus.op_i;
            // Remainder takes the dividend's sign; products and quotients the xor.
            neg_d   = (bus.op_i[2] && bus.op_i[1]) ? sign_a : (sign_a ^ sign_b);
            if (bus.op_i[2]) begin
              acc_d  = {{XLEN{1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {{XLEN{1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            result_d = final_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o   = (state_q == CALC);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = result_q;
endmodule
